// File: rtl/shift_pkg.sv
// Shared types and default sizing for the shift controller.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int WIDTH_DEF    = 20;
  localparam int STEP_MAX_DEF = 4;

endpackage

// File: rtl/shift_ctrl_if.sv
// Request/response handshake bundle between a requester and shift_ctrl.
interface shift_ctrl_if #(
  parameter int WIDTH = shift_pkg::WIDTH_DEF
) ();

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_data;
  logic [4:0]       req_amt;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;

  modport master (
    output req_valid, req_op, req_data, req_amt, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_amt, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/shift_ctrl_step.sv
// Single combinational shift step of 0..STEP_MAX bits.
// Rotate datapath exists only when SHIFT_CTRL_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic [WIDTH-1:0]               value_i,
  input  op_e                            op_i,
  input  logic                           sign_i,
  input  logic [$clog2(STEP_MAX+1)-1:0]  s_i,
  output logic [WIDTH-1:0]               value_o
);

  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL: value_o = value_i << s_i;
      OP_SRL: value_o = value_i >> s_i;
      // Fill from the latched sign rather than the working MSB.
      OP_SRA: value_o = (value_i >> s_i) | ({WIDTH{sign_i}} & ~({WIDTH{1'b1}} >> s_i));
`ifdef SHIFT_CTRL_ROTATE_EN
      OP_ROL: value_o = (value_i << s_i) | (value_i >> (WIDTH - int'(s_i)));
`else
      OP_ROL: value_o = value_i;
`endif
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Multi-cycle shift controller: applies up to STEP_MAX bits per cycle.
// ROL supported only when SHIFT_CTRL_ROTATE_EN is defined, else flagged as error.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  shift_ctrl_if.slave  bus,
  output logic         busy
);

  // state | meaning
  // IDLE  | ready for a request
  // SHIFT | stepping the working register
  // DONE  | response held until resp_ready

  localparam int RW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(STEP_MAX + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sign_q, sign_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             err_q, err_d;

  op_e              req_op;
  logic [RW-1:0]    eff;
  logic             rol_unsup;
  logic [SW-1:0]    step_s;
  logic [WIDTH-1:0] step_out;

  assign req_op = op_e'(bus.req_op);

`ifdef SHIFT_CTRL_ROTATE_EN
  assign rol_unsup = 1'b0;
`else
  assign rol_unsup = (req_op == OP_ROL);
`endif

  always_comb begin
    eff = '0;
    if (req_op == OP_ROL) begin
`ifdef SHIFT_CTRL_ROTATE_EN
      eff = RW'(int'(bus.req_amt) % WIDTH);
`else
      eff = '0;
`endif
    end else if (int'(bus.req_amt) >= WIDTH) begin
      eff = RW'(WIDTH);
    end else begin
      eff = RW'(bus.req_amt);
    end
  end

  assign step_s = (int'(rem_q) > STEP_MAX) ? SW'(STEP_MAX) : SW'(rem_q);

  shift_step #(
    .WIDTH    (WIDTH),
    .STEP_MAX (STEP_MAX)
  ) u_step (
    .value_i (data_q),
    .op_i    (op_q),
    .sign_i  (sign_q),
    .s_i     (step_s),
    .value_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d   = req_op;
          data_d = bus.req_data;
          sign_d = bus.req_data[WIDTH-1];
          err_d  = 1'b0;
          rem_d  = eff;
          if (rol_unsup) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = DONE;
          end else if (eff == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - RW'(step_s);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      data_q  <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed self-checking bench for shift_ctrl (WIDTH=20, STEP_MAX=4).
// Honours SHIFT_CTRL_ROTATE_EN for the ROL expectations.
module tb_shift_ctrl;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;

  shift_ctrl_if #(.WIDTH(20)) bus ();

  shift_ctrl #(.WIDTH(20), .STEP_MAX(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge (counted as 1), then consume.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [19:0] data,
                         input logic [4:0] amt, input logic [19:0] exp_data,
                         input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    bus.req_amt   = amt;
    lat = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!bus.resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, {12'd0, bus.resp_data}, {12'd0, exp_data});
    check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, bus.resp_valid, busy}, 32'd0);
  endtask

  initial begin
    logic [19:0] held;
    logic        saw_valid;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_data   = '0;
    bus.req_amt    = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_data", {12'd0, bus.resp_data}, 32'd0);
    check("rst_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    run_req("sll5",    2'b00, 20'h00001,  5, 20'h00020, 1'b0, 3);
    run_req("sra19",   2'b10, 20'h80000, 19, 20'hFFFFF, 1'b0, 6);
    run_req("srl25",   2'b01, 20'hFFFFF, 25, 20'h00000, 1'b0, 6);
    run_req("sll0",    2'b00, 20'h12345,  0, 20'h12345, 1'b0, 1);
    run_req("srl0",    2'b01, 20'hABCDE,  0, 20'hABCDE, 1'b0, 1);
    run_req("sra0",    2'b10, 20'h80001,  0, 20'h80001, 1'b0, 1);
    run_req("sra_pos", 2'b10, 20'h40000,  3, 20'h08000, 1'b0, 2);
    run_req("sra_neg", 2'b10, 20'h8F000,  4, 20'hF8F00, 1'b0, 2);
    run_req("sll20",   2'b00, 20'hABCDE, 20, 20'h00000, 1'b0, 6);
    run_req("sra31",   2'b10, 20'h7FFFF, 31, 20'h00000, 1'b0, 6);
    run_req("srl8",    2'b01, 20'hABCDE,  8, 20'h00ABC, 1'b0, 3);
`ifdef SHIFT_CTRL_ROTATE_EN
    run_req("rol21",   2'b11, 20'h80001, 21, 20'h00003, 1'b0, 2);
    run_req("rol24",   2'b11, 20'h12345, 24, 20'h23451, 1'b0, 2);
    run_req("rol0",    2'b11, 20'h12345,  0, 20'h12345, 1'b0, 1);
`else
    run_req("rol21",   2'b11, 20'h80001, 21, 20'h80001, 1'b1, 1);
    run_req("rol24",   2'b11, 20'h12345, 24, 20'h12345, 1'b1, 1);
`endif

    // Backpressure in DONE with a competing request present
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_data  = 20'h00001;
    bus.req_amt   = 5'd1;
    @(negedge clk);
    bus.req_data  = 20'h00003;
    bus.req_amt   = 5'd0;
    @(negedge clk);
    check("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
    held = bus.resp_data;
    check("bp_data0", {12'd0, held}, 32'h00002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {12'd0, bus.resp_data}, {12'd0, held});
      check("bp_noready", {30'd0, bus.req_ready, bus.resp_valid}, 32'd1);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_idle", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_next_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("bp_next_data", {12'd0, bus.resp_data}, 32'h00003);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // Reset during the second SHIFT cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_data  = 20'hFFFFF;
    bus.req_amt   = 5'd12;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("mid_rst_data", {12'd0, bus.resp_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    saw_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) saw_valid = 1'b1;
    end
    check("mid_no_resp", {31'd0, saw_valid}, 32'd0);
    run_req("post_rst", 2'b10, 20'h80000, 5, 20'hFC000, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 20, data width in bits.
- STEP_MAX, 4, maximum shift distance applied per step cycle (1..WIDTH).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- req_data  input  WIDTH  operand.
- req_amt  input  5  requested shift distance (0..31).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  WIDTH  shifted result.
- resp_err  output  1  unsupported operation flag, qualified by resp_valid.
- busy  output  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-004 req_ready SHALL be 1 only in IDLE, so a request is accepted only on an edge where req_valid=1 and the state is IDLE.
REQ-005 On accept, the controller SHALL latch op and data and compute the effective distance eff:
- SLL, SRL, SRA: eff = min(req_amt, WIDTH).
- ROL: eff = req_amt mod WIDTH.
REQ-006 Accept transitions:
- eff = 0: go to DONE; resp_data equals the operand.
- eff > 0: go to SHIFT with remaining = eff.
REQ-007 Each SHIFT cycle SHALL shift the working register by s = min(remaining, STEP_MAX) and decrement remaining by s.
REQ-008 Shift fill rules:
- SLL fills zeros at the LSB end.
- SRL fills zeros at the MSB end.
- SRA fills with the latched operand's MSB.
- ROL wraps bits from the MSB end into the LSB end.
REQ-009 When remaining reaches 0, the FSM SHALL enter DONE on that same edge.
REQ-010 Latency from the accept edge to resp_valid=1 SHALL be 1 + ceil(eff/STEP_MAX) cycles.
REQ-011 In DONE, resp_valid SHALL be 1 and resp_data/resp_err SHALL be held stable until an edge with resp_ready=1; that edge returns the FSM to IDLE.
REQ-012 resp_ready SHALL be ignored outside DONE, and req_* inputs SHALL be ignored outside IDLE.
REQ-013 A new request SHALL NOT be accepted on the same edge as the response handshake; the earliest next accept is the following edge.
REQ-014 Outcomes for over-range distances:
- SLL/SRL with req_amt >= WIDTH SHALL return 0.
- SRA with req_amt >= WIDTH SHALL return all copies of the sign bit.

Reset
REQ-015 While rst=1, the controller SHALL asynchronously force:
- state IDLE;
- req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0;
- remaining=0.
REQ-016 A reset asserted during SHIFT or DONE SHALL discard the operation with no response emitted; normal operation resumes on the first edge after rst deasserts.

Configuration
REQ-017 Macro SHIFT_CTRL_ROTATE_EN governs the ROL operation.
- Defined: op 11 performs ROL and resp_err is always 0.
- Undefined: op 11 goes directly to DONE with resp_data equal to the operand and resp_err=1; no rotate logic is synthesized.

Structure
REQ-018 A shared package shift_pkg SHALL hold:
- the op encoding typedef (SLL, SRL, SRA, ROL);
- the FSM state typedef;
- the default WIDTH and STEP_MAX constants.
REQ-019 One combinational sub-module, shift_step, SHALL perform a single step: inputs value, op, sign and s (0..STEP_MAX); output the shifted value. shift_ctrl SHALL instantiate it once.

Verification
REQ-020 SLL, data 0x00001, amt 5, STEP_MAX 4 -> 2 SHIFT cycles; resp_valid rises 3 cycles after accept; resp_data=0x00020; resp_err=0.
REQ-021 SRA, data 0x80000, amt 19 -> resp_data=0xFFFFF after 1+5 cycles. SRL, data 0xFFFFF, amt 25 -> resp_data=0x00000 after 1+5 cycles.
REQ-022 amt 0, any op except unsupported ROL -> resp_valid 1 cycle after accept; resp_data equals operand.
REQ-023 ROL, data 0x80001, amt 21:
- Macro defined -> resp_data=0x00003, resp_err=0.
- Macro undefined -> resp_data=0x80001, resp_err=1, 1-cycle latency.
REQ-024 Backpressure: hold resp_ready=0 for 3 cycles in DONE -> resp_data stable, req_ready=0, req_valid ignored. Then raise resp_ready -> IDLE on the next edge; next accept no earlier than 1 cycle later.
REQ-025 Reset mid-operation: assert rst during the 2nd SHIFT cycle -> outputs reach reset values immediately (asynchronously) and no resp_valid pulse occurs; a fresh request after release completes correctly.
